// File: rtl/text_display_char_fifo_if.sv
// Character FIFO bus: CPU push side, display-controller pop side and
// the status the CPU polls (full/empty/count/overflow).
interface text_display_char_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              rd_en;
    logic [6:0]        fifo_out;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;

    // Producer/consumer side (CPU port + display controller).
    modport master (
        output wr_en, wr_data, rd_en, clr_ovf,
        input  full, fifo_out, empty, count, overflow
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, rd_en, clr_ovf,
        output full, fifo_out, empty, count, overflow
    );
endinterface

// File: rtl/text_display_char_fifo.sv
// First-word-fall-through character queue between the CPU output port and
// the text display controller. Stores 7-bit font ROM codes, reports
// occupancy, and latches a sticky overflow flag when a push is dropped.
module text_display_char_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    text_display_char_fifo_if.slave    bus
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [6:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;

    logic              is_full;
    logic              is_empty;
    logic              pop_ok;
    logic              push_ok;
    logic              push_drop;

    // Bit 7 of the ASCII byte carries no font information and is dropped.
    logic              unused_ascii_msb;
    assign unused_ascii_msb = bus.wr_data[7];

    // Status decoded from the registered occupancy counter.
    assign is_full  = (cnt == CNT_MAX);
    assign is_empty = (cnt == '0);

    // A pop needs data; a push needs space, or a slot freed by a pop in the
    // same cycle. At empty there is no bypass, so a concurrent pop is ignored.
    assign pop_ok    = bus.rd_en & ~is_empty;
    assign push_ok   = bus.wr_en & (~is_full | pop_ok);
    assign push_drop = bus.wr_en & is_full & ~pop_ok;

    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
    assign bus.fifo_out = mem[rd_ptr];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= bus.wr_data[6:0];
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow; a dropped push beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push_drop) begin
            ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: doc/text_display_char_fifo.md
# text_display_char_fifo

Character FIFO that feeds the text display path. The CPU-side output port pushes ASCII bytes in. The display controller pops 7-bit character codes out; these are the font ROM addresses it latches into its buffer register. The block is a first-word-fall-through queue with full/empty/count status and a sticky overflow flag, so software can poll it and detect dropped characters.

## Interface
Parameters:
- ADDR_W, 4, pointer width; depth = 2^ADDR_W entries (default 16)

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  reset rst, synchronous, active-high; clock clk
- wr_en  input  1  push request from CPU output port
- wr_data  input  8  ASCII byte; only bits [6:0] are stored, bit 7 is discarded
- full  output  1  high when count == 2^ADDR_W
- rd_en  input  1  pop request from display controller (same cycle it loads its buffer register)
- fifo_out  output  7  character code at head of queue; valid only while empty=0
- empty  output  1  high when count == 0
- count  output  ADDR_W+1  number of stored entries, 0..2^ADDR_W
- overflow  output  1  sticky; set when a push is dropped
- clr_ovf  input  1  clears overflow

## Operation
- Storage: 2^ADDR_W x 7-bit array, write pointer wr_ptr and read pointer rd_ptr (ADDR_W bits each, wrap modulo depth), occupancy counter count.
- fifo_out = mem[rd_ptr], read combinationally (first-word-fall-through); no extra read latency.
- Push accepted when wr_en=1 and (full=0 or rd_en=1 with empty=0): mem[wr_ptr] <= wr_data[6:0], wr_ptr <= wr_ptr+1.
- Pop accepted when rd_en=1 and empty=0: rd_ptr <= rd_ptr+1.
- count: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither.
- Full with simultaneous wr_en and rd_en: both accepted, count stays at depth. Head entry leaves before its slot is overwritten (wr_ptr == rd_ptr, write lands in freed slot).
- Empty with simultaneous wr_en and rd_en: push accepted, pop ignored (no bypass); count becomes 1; fifo_out shows new data next cycle.
- Pop while empty: ignored; pointers, count and flags unchanged; no error flag.
- Push dropped (wr_en=1, full=1, no accepted pop): memory and pointers unchanged; overflow <= 1.
- overflow: cleared by rst or clr_ovf. If clr_ovf and a dropping push happen in the same cycle, set wins (overflow=1).
- Pointer wrap: after entry 2^ADDR_W-1, pointers return to 0; no gap or duplicate.

## Timing
- Reset values (cycle after rst sampled high): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0. Memory contents are not reset; fifo_out is don't-care while empty=1.
- rst overrides all inputs in the same cycle. Reset mid-operation discards all queued characters.
- full, empty and count are registered-derived (decoded from count). They update the cycle after the accepted push/pop edge.
- Write-to-read latency: a byte pushed at edge N appears on fifo_out with empty=0 after edge N (usable by a pop at edge N+1).
- Pop: fifo_out advances to the next entry immediately after the edge that accepts rd_en.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset/basic: assert rst 1 cycle -> empty=1, full=0, count=0, overflow=0. Push 0x41 -> next cycle fifo_out=7'h41, count=1. Pop -> empty=1.
- Bit-7 strip and order: push 0xC8, 0x69, 0x21 -> pops return 7'h48, 7'h69, 7'h21 in order.
- Fill/overflow: push 16 distinct codes -> full=1, count=16. A 17th push (0x7A) -> dropped, overflow=1, count=16. Draining returns the original 16 codes. clr_ovf -> overflow=0.
- Simultaneous at full: full FIFO, wr_en+rd_en with 0x55 -> head popped, count=16, 0x55 is last out.
- Simultaneous at empty / underflow: empty, wr_en+rd_en with 0x30 -> count=1, fifo_out=7'h30. Pop on empty -> no change in count or pointers.
- Wrap and mid-op reset: 40 interleaved push/pop cycles crossing the pointer wrap -> data matches scoreboard. rst with count=5 -> count=0, empty=1 next cycle.
